// File: rtl/mac_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mac_norm_pipe
// Description : Two-stage valid/ready normalisation pipeline ahead of the FP16
//               MAC exponent/output formatter. Stage 1 finds the leading one
//               of the accumulator magnitude and classifies the sum as zero,
//               flush (leading one below bit 6) or normal. Stage 2 barrel-
//               shifts the magnitude so the leading one lands on bit 10 and
//               registers every formatter-facing output.
//
// Ports       : clk, rst_n (async, active-low)
//               in_valid / in_ready      upstream handshake
//               sum_mag[23:0], sum_sign  sign/magnitude accumulator sum
//               max_exp_in[5:0]          block max exponent (passthrough)
//               q_frac_in[4:0]           fraction offset (passthrough)
//               out_valid / out_ready    downstream handshake
//               norm_sum_with_leading1   11-bit significand, leading one at b10
//               signed_exp_diff[4:0]     two's-complement exponent correction
//               exp_carry                sum occupied bit 23
//               sign, max_exp, Q_frac    registered passthroughs
//               flush_cnt[7:0]           saturating count of flushed sums
//
// Revision    : 1.0 - initial release
// ============================================================================
module mac_norm_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] sum_mag,
    input  logic        sum_sign,
    input  logic [5:0]  max_exp_in,
    input  logic [4:0]  q_frac_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] norm_sum_with_leading1,
    output logic [4:0]  signed_exp_diff,
    output logic        exp_carry,
    output logic        sign,
    output logic [5:0]  max_exp,
    output logic [4:0]  Q_frac,
    output logic [7:0]  flush_cnt
);

    localparam logic [4:0] c_top_pos   = 5'd23;  // sum overflowed into bit 23
    localparam logic [4:0] c_ref_pos   = 5'd22;  // position giving zero correction
    localparam logic [4:0] c_flush_pos = 5'd6;   // below this the sum is flushed
    localparam logic [7:0] c_cnt_max   = 8'hFF;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic w_s2_adv;
    logic w_s1_adv;

    assign w_s2_adv = !r_v2 || out_ready;
    assign w_s1_adv = !r_v1 || w_s2_adv;
    assign in_ready = w_s1_adv;   // equals !v1 | !v2 | out_ready
    assign out_valid = r_v2;

    // ------------------------------------------------------------------
    // Stage 1: leading-one detection
    // ------------------------------------------------------------------
    logic [4:0] w_pos;
    logic       w_zero;
    logic       w_flush;

    always_comb begin
        w_pos = '0;
        // Ascending scan: the highest set bit is the last one written.
        for (int i = 0; i < 24; i++) begin
            if (sum_mag[i]) begin
                w_pos = 5'(i);
            end
        end
    end

    assign w_zero  = (sum_mag == 24'd0);
    assign w_flush = !w_zero && (w_pos < c_flush_pos);

    logic [23:0] r1_mag;
    logic        r1_sign;
    logic [5:0]  r1_max_exp;
    logic [4:0]  r1_q_frac;
    logic [4:0]  r1_pos;
    logic        r1_zero;
    logic        r1_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r1_mag     <= '0;
            r1_sign    <= 1'b0;
            r1_max_exp <= '0;
            r1_q_frac  <= '0;
            r1_pos     <= '0;
            r1_zero    <= 1'b0;
            r1_flush   <= 1'b0;
        end else if (w_s1_adv) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r1_mag     <= sum_mag;
                r1_sign    <= sum_sign;
                r1_max_exp <= max_exp_in;
                r1_q_frac  <= q_frac_in;
                r1_pos     <= w_pos;
                r1_zero    <= w_zero;
                r1_flush   <= w_flush;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: barrel shift and output mapping
    // ------------------------------------------------------------------
    logic [4:0]  w_shamt;
    logic [23:0] w_shifted;
    logic [10:0] w_norm;
    logic [4:0]  w_diff;
    logic        w_carry;
    logic        w_unused_bits;

    // Only meaningful for pos 6..22; at pos 23 the wrapped amount is ignored.
    assign w_shamt   = c_ref_pos - r1_pos;
    assign w_shifted = r1_mag << w_shamt;
    assign w_unused_bits = ^{w_shifted[23], w_shifted[11:0]};

    always_comb begin
        w_norm  = '0;
        w_diff  = '0;
        w_carry = 1'b0;
        if (r1_zero || r1_flush) begin
            w_norm  = '0;
            w_diff  = '0;
            w_carry = 1'b0;
        end else if (r1_pos == c_top_pos) begin
            w_norm  = r1_mag[23:13];
            w_carry = 1'b1;
        end else begin
            w_norm = w_shifted[22:12];
            // Wraps to the negative correction for pos < 22.
            w_diff = r1_pos - c_ref_pos;
        end
    end

    logic [10:0] r2_norm;
    logic [4:0]  r2_diff;
    logic        r2_carry;
    logic        r2_sign;
    logic [5:0]  r2_max_exp;
    logic [4:0]  r2_q_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2       <= 1'b0;
            r2_norm    <= '0;
            r2_diff    <= '0;
            r2_carry   <= 1'b0;
            r2_sign    <= 1'b0;
            r2_max_exp <= '0;
            r2_q_frac  <= '0;
        end else if (w_s2_adv) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r2_norm    <= w_norm;
                r2_diff    <= w_diff;
                r2_carry   <= w_carry;
                r2_sign    <= r1_sign;
                r2_max_exp <= r1_max_exp;
                r2_q_frac  <= r1_q_frac;
            end
        end
    end

    assign norm_sum_with_leading1 = r2_norm;
    assign signed_exp_diff        = r2_diff;
    assign exp_carry              = r2_carry;
    assign sign                   = r2_sign;
    assign max_exp                = r2_max_exp;
    assign Q_frac                 = r2_q_frac;

    // ------------------------------------------------------------------
    // Flush counter: counts flush beats as they move into stage 2
    // ------------------------------------------------------------------
    logic [7:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if (w_s2_adv && r_v1 && r1_flush && (r_flush_cnt != c_cnt_max)) begin
            r_flush_cnt <= r_flush_cnt + 8'd1;
        end
    end

    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
